// File: rtl/brick_tracker.sv
// ---------------------------------------------------------------------------
// brick_tracker
//   Tracks a 4x8 wall of bricks for a breakout-style game. Once per frame it
//   walks the present bricks in ascending order looking for the first one
//   the ball overlaps. That brick is cleared and the BCD score is bumped,
//   saturating at 9999. A lost ball consumes a life instead of scanning.
//
// Ports
//   Clk          system clock
//   Reset        asynchronous, active-high reset
//   frame_clk    per-frame strobe (level); its rising edge starts a frame
//   start        synchronous new-game request; overrides everything else
//   BallX/BallY  ball centre in pixels
//   Ball_size    ball radius in pixels
//   ball_lost    ball has left the bottom of the screen
//   Block_Array  brick present flags, bit 32 tied to 0
//   lives        remaining lives
//   score_bcd    four-digit BCD score, [15:12] most significant
//   hit          one-cycle pulse when a brick is cleared
//   hit_index    index of the last cleared brick
//   game_over    lives exhausted
//   level_clear  every brick cleared
// ---------------------------------------------------------------------------
module brick_tracker #(
    parameter int BLOCK_HALF_X = 39,
    parameter int BLOCK_HALF_Y = 9
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  Ball_size,
    input  logic        ball_lost,
    output logic [32:0] Block_Array,
    output logic [1:0]  lives,
    output logic [15:0] score_bcd,
    output logic        hit,
    output logic [4:0]  hit_index,
    output logic        game_over,
    output logic        level_clear
);

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

    state_t      state;
    state_t      state_next;
    logic        frame_prev;
    logic        frame_event;
    logic [4:0]  scan_idx;
    logic [4:0]  hit_latch;
    logic [31:0] bricks;
    logic [15:0] score;
    logic        scan_go;
    logic        lose_life;
    logic        scan_hit;
    logic        do_update;

    // Overlap of the ball with brick idx. Everything is widened to 12-bit
    // signed so the distance and the reach never wrap.
    function automatic logic brick_overlap(input logic [4:0] idx,
                                           input logic [9:0] bx,
                                           input logic [9:0] by,
                                           input logic [9:0] bs);
        logic signed [11:0] cx;
        logic signed [11:0] cy;
        logic signed [11:0] dx;
        logic signed [11:0] dy;
        logic signed [11:0] lim_x;
        logic signed [11:0] lim_y;
        cx    = signed'(12'(idx[2:0]) * 12'd80 + 12'd40);
        cy    = signed'(12'd10 + 12'(idx[4:3]) * 12'd20);
        dx    = signed'({2'b00, bx}) - cx;
        dy    = signed'({2'b00, by}) - cy;
        dx    = (dx < 0) ? -dx : dx;
        dy    = (dy < 0) ? -dy : dy;
        lim_x = signed'(12'(BLOCK_HALF_X)) + signed'({2'b00, bs});
        lim_y = signed'(12'(BLOCK_HALF_Y)) + signed'({2'b00, bs});
        return (dx <= lim_x) && (dy <= lim_y);
    endfunction

    // Decimal increment with ripple carry between nibbles; 9999 sticks.
    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value == 16'h9999) begin
            return value;
        end
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (value[d*4 +: 4] == 4'd9) begin
                    result[d*4 +: 4] = 4'd0;
                end else begin
                    result[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

    assign frame_event = frame_clk & ~frame_prev;
    assign game_over   = (lives == 2'd0);
    assign level_clear = (bricks == 32'h0);
    assign Block_Array = {1'b0, bricks};
    assign score_bcd   = score;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else if (start) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scan_go) state_next = SCAN;
            SCAN:    if (scan_hit) state_next = UPDATE;
                     else if (scan_idx == 5'd31) state_next = IDLE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes. Frame events seen outside IDLE fall through here
    // unused, so they are dropped rather than queued.
    always_comb begin
        scan_go   = 1'b0;
        lose_life = 1'b0;
        scan_hit  = 1'b0;
        do_update = 1'b0;
        case (state)
            IDLE: begin
                if (frame_event && !game_over && !level_clear) begin
                    lose_life = ball_lost;
                    scan_go   = ~ball_lost;
                end
            end
            SCAN:    scan_hit  = bricks[scan_idx] &&
                                 brick_overlap(scan_idx, BallX, BallY, Ball_size);
            UPDATE:  do_update = 1'b1;
            default: ;
        endcase
    end

    // Game state and scan bookkeeping
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_prev <= 1'b0;
            scan_idx   <= 5'd0;
            hit_latch  <= 5'd0;
            bricks     <= '1;
            lives      <= 2'd3;
            score      <= 16'h0000;
            hit        <= 1'b0;
            hit_index  <= 5'd0;
        end else begin
            frame_prev <= frame_clk;
            hit        <= 1'b0;
            if (start) begin
                scan_idx  <= 5'd0;
                bricks    <= '1;
                lives     <= 2'd3;
                score     <= 16'h0000;
                hit_index <= 5'd0;
            end else begin
                if (scan_go) begin
                    scan_idx <= 5'd0;
                end else if (state == SCAN && !scan_hit) begin
                    scan_idx <= scan_idx + 5'd1;
                end
                if (scan_hit) begin
                    hit_latch <= scan_idx;
                end
                if (lose_life) begin
                    lives <= lives - 2'd1;
                end
                if (do_update) begin
                    bricks[hit_latch] <= 1'b0;
                    hit               <= 1'b1;
                    hit_index         <= hit_latch;
                    score             <= bcd_inc_sat(score);
                end
            end
        end
    end

endmodule

// File: tb/tb_brick_tracker.sv
// ---------------------------------------------------------------------------
// tb_brick_tracker
//   Directed bench for brick_tracker. Each scenario task drives its own
//   stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_brick_tracker;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        start;
    logic [9:0]  BallX;
    logic [9:0]  BallY;
    logic [9:0]  Ball_size;
    logic        ball_lost;
    logic [32:0] Block_Array;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic        hit;
    logic [4:0]  hit_index;
    logic        game_over;
    logic        level_clear;

    int checks   = 0;
    int failures = 0;

    brick_tracker dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .start       (start),
        .BallX       (BallX),
        .BallY       (BallY),
        .Ball_size   (Ball_size),
        .ball_lost   (ball_lost),
        .Block_Array (Block_Array),
        .lives       (lives),
        .score_bcd   (score_bcd),
        .hit         (hit),
        .hit_index   (hit_index),
        .game_over   (game_over),
        .level_clear (level_clear)
    );

    always #5 Clk = ~Clk;

    task automatic set_ball(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
        BallX     = x;
        BallY     = y;
        Ball_size = s;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        frame_clk = 1'b0;
        start     = 1'b0;
        ball_lost = 1'b0;
        Reset     = 1'b1;
        #2;
        Reset     = 1'b0;
    endtask

    // One frame_clk pulse, then wait (bounded) for a hit. lat counts
    // negedges after frame_clk falls; 0 when no hit arrived.
    task automatic frame_and_wait(output logic got, output int lat);
        got = 1'b0;
        lat = 0;
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (hit === 1'b1) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; ball_lost = 1'b0;
        set_ball(10'd0, 10'd0, 10'd0);
        #1;
        checks++; if (Block_Array !== 33'h0_FFFF_FFFF) begin failures++; $display("FAIL reset_bricks: got %h need %h", Block_Array, 33'h0_FFFF_FFFF); end
        checks++; if (lives !== 2'd3) begin failures++; $display("FAIL reset_lives: got %0d need 3", lives); end
        checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL reset_score: got %h need 0000", score_bcd); end
        checks++; if (hit !== 1'b0 || hit_index !== 5'd0) begin failures++; $display("FAIL reset_hit: got hit=%b idx=%0d need 0/0", hit, hit_index); end
        checks++; if (game_over !== 1'b0 || level_clear !== 1'b0) begin failures++; $display("FAIL reset_flags: got go=%b lc=%b need 0/0", game_over, level_clear); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_single_hit();
        logic got; int lat;
        do_reset();
        set_ball(10'd40, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 2) begin failures++; $display("FAIL single_latency: got hit=%b lat=%0d need 1/2", got, lat); end
        checks++; if (hit_index !== 5'd0) begin failures++; $display("FAIL single_index: got %0d need 0", hit_index); end
        checks++; if (Block_Array !== 33'h0_FFFF_FFFE) begin failures++; $display("FAIL single_bricks: got %h need 0fffffffe", Block_Array); end
        checks++; if (score_bcd !== 16'h0001) begin failures++; $display("FAIL single_score: got %h need 0001", score_bcd); end
        @(negedge Clk);
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL single_pulse_width: got %b need 0", hit); end
    endtask

    task automatic test_one_per_frame();
        logic got; int lat;
        do_reset();
        set_ball(10'd80, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || hit_index !== 5'd0 || Block_Array !== 33'h0_FFFF_FFFE) begin failures++; $display("FAIL one_per_frame_1: got hit=%b idx=%0d bricks=%h need 1/0/0fffffffe", got, hit_index, Block_Array); end
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 3 || hit_index !== 5'd1) begin failures++; $display("FAIL one_per_frame_2: got hit=%b lat=%0d idx=%0d need 1/3/1", got, lat, hit_index); end
        checks++; if (Block_Array !== 33'h0_FFFF_FFFC || score_bcd !== 16'h0002) begin failures++; $display("FAIL one_per_frame_state: got bricks=%h score=%h need 0fffffffc/0002", Block_Array, score_bcd); end
    endtask

    task automatic test_no_hit();
        logic got; int lat; int nhits;
        nhits = 0;
        set_ball(10'd320, 10'd300, 10'd10);
        for (int f = 0; f < 10; f++) begin
            frame_and_wait(got, lat);
            if (got === 1'b1) nhits++;
        end
        checks++; if (nhits != 0) begin failures++; $display("FAIL no_hit_count: got %0d need 0", nhits); end
        checks++; if (Block_Array !== 33'h0_FFFF_FFFC || score_bcd !== 16'h0002) begin failures++; $display("FAIL no_hit_state: got bricks=%h score=%h need 0fffffffc/0002", Block_Array, score_bcd); end
        set_ball(10'd200, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 4 || hit_index !== 5'd2) begin failures++; $display("FAIL no_hit_rescan: got hit=%b lat=%0d idx=%0d need 1/4/2", got, lat, hit_index); end
    endtask

    task automatic test_boundary();
        logic got; int lat;
        do_reset();
        set_ball(10'd84, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 3 || hit_index !== 5'd1) begin failures++; $display("FAIL edge_x_outside: got hit=%b lat=%0d idx=%0d need 1/3/1", got, lat, hit_index); end
        set_ball(10'd83, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 2 || hit_index !== 5'd0) begin failures++; $display("FAIL edge_x_inside: got hit=%b lat=%0d idx=%0d need 1/2/0", got, lat, hit_index); end
        do_reset();
        set_ball(10'd40, 10'd24, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 10 || hit_index !== 5'd8) begin failures++; $display("FAIL edge_y_outside: got hit=%b lat=%0d idx=%0d need 1/10/8", got, lat, hit_index); end
        set_ball(10'd40, 10'd23, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 2 || hit_index !== 5'd0) begin failures++; $display("FAIL edge_y_inside: got hit=%b lat=%0d idx=%0d need 1/2/0", got, lat, hit_index); end
        set_ball(10'd600, 10'd70, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 33 || hit_index !== 5'd31) begin failures++; $display("FAIL last_brick: got hit=%b lat=%0d idx=%0d need 1/33/31", got, lat, hit_index); end
    endtask

    task automatic test_frame_ignored();
        int nhits;
        nhits = 0;
        do_reset();
        set_ball(10'd560, 10'd70, 10'd4);
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        for (int i = 0; i < 90; i++) begin
            @(negedge Clk);
            if (hit === 1'b1) nhits++;
        end
        checks++; if (nhits != 1 || hit_index !== 5'd30) begin failures++; $display("FAIL frame_in_scan: got hits=%0d idx=%0d need 1/30", nhits, hit_index); end
        checks++; if (Block_Array !== 33'h0_BFFF_FFFF) begin failures++; $display("FAIL frame_in_scan_bricks: got %h need 0bfffffff", Block_Array); end
    endtask

    task automatic test_score_sat();
        logic got; int lat;
        do_reset();
        @(negedge Clk);
        force dut.score = 16'h9998;
        #1 release dut.score;
        set_ball(10'd40, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || score_bcd !== 16'h9999) begin failures++; $display("FAIL score_to_9999: got hit=%b score=%h need 1/9999", got, score_bcd); end
        set_ball(10'd120, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || hit_index !== 5'd1 || score_bcd !== 16'h9999) begin failures++; $display("FAIL score_saturate: got hit=%b idx=%0d score=%h need 1/1/9999", got, hit_index, score_bcd); end
        checks++; if (Block_Array !== 33'h0_FFFF_FFFC) begin failures++; $display("FAIL score_saturate_bricks: got %h need 0fffffffc", Block_Array); end
        @(negedge Clk);
        force dut.score = 16'h0999;
        #1 release dut.score;
        set_ball(10'd200, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || score_bcd !== 16'h1000) begin failures++; $display("FAIL score_carry: got hit=%b score=%h need 1/1000", got, score_bcd); end
    endtask

    task automatic test_reset_mid_scan();
        int nhits;
        nhits = 0;
        set_ball(10'd600, 10'd70, 10'd4);
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (10) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        checks++; if (Block_Array !== 33'h0_FFFF_FFFF || score_bcd !== 16'h0000) begin failures++; $display("FAIL midscan_reset_data: got bricks=%h score=%h need 0ffffffff/0000", Block_Array, score_bcd); end
        checks++; if (lives !== 2'd3 || hit !== 1'b0 || hit_index !== 5'd0) begin failures++; $display("FAIL midscan_reset_ctrl: got lives=%0d hit=%b idx=%0d need 3/0/0", lives, hit, hit_index); end
        #1 Reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (hit === 1'b1) nhits++;
        end
        checks++; if (nhits != 0 || score_bcd !== 16'h0000 || Block_Array !== 33'h0_FFFF_FFFF) begin failures++; $display("FAIL midscan_abandon: got hits=%0d score=%h bricks=%h need 0/0000/0ffffffff", nhits, score_bcd, Block_Array); end
    endtask

    task automatic test_lives();
        logic got; int lat;
        logic [1:0] exp_lives;
        do_reset();
        set_ball(10'd40, 10'd10, 10'd4);
        frame_and_wait(got, lat);
        set_ball(10'd120, 10'd10, 10'd4);
        ball_lost = 1'b1;
        for (int f = 0; f < 4; f++) begin
            frame_and_wait(got, lat);
            exp_lives = (f < 3) ? 2'(2 - f) : 2'd0;
            checks++; if (lives !== exp_lives || game_over !== (f >= 2) || got !== 1'b0) begin failures++; $display("FAIL lost_frame_%0d: got lives=%0d go=%b hit=%b need %0d/%0d/0", f, lives, game_over, got, exp_lives, (f >= 2)); end
        end
        ball_lost = 1'b0;
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b0 || Block_Array !== 33'h0_FFFF_FFFE || score_bcd !== 16'h0001) begin failures++; $display("FAIL game_over_hold: got hit=%b bricks=%h score=%h need 0/0fffffffe/0001", got, Block_Array, score_bcd); end
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
        checks++; if (lives !== 2'd3 || score_bcd !== 16'h0000 || Block_Array !== 33'h0_FFFF_FFFF || game_over !== 1'b0) begin failures++; $display("FAIL start_restart: got lives=%0d score=%h bricks=%h go=%b need 3/0000/0ffffffff/0", lives, score_bcd, Block_Array, game_over); end
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b1 || lat != 3 || hit_index !== 5'd1) begin failures++; $display("FAIL start_play: got hit=%b lat=%0d idx=%0d need 1/3/1", got, lat, hit_index); end
    endtask

    task automatic test_level_clear();
        logic got; int lat; int errs;
        errs = 0;
        do_reset();
        set_ball(10'd320, 10'd40, 10'd1000);
        for (int k = 0; k < 32; k++) begin
            frame_and_wait(got, lat);
            if (got !== 1'b1 || lat != 2 + k || hit_index !== 5'(k)) errs++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL clear_sequence: got %0d bad frames need 0", errs); end
        checks++; if (level_clear !== 1'b1 || Block_Array !== 33'h0 || score_bcd !== 16'h0032) begin failures++; $display("FAIL clear_state: got lc=%b bricks=%h score=%h need 1/000000000/0032", level_clear, Block_Array, score_bcd); end
        frame_and_wait(got, lat);
        checks++; if (got !== 1'b0 || score_bcd !== 16'h0032 || game_over !== 1'b0) begin failures++; $display("FAIL clear_hold: got hit=%b score=%h go=%b need 0/0032/0", got, score_bcd, game_over); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_one_per_frame();
        test_no_hit();
        test_boundary();
        test_frame_ignored();
        test_score_sat();
        test_reset_mid_scan();
        test_lives();
        test_level_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
